// File: rtl/pe_column_ctrl.sv
// Sequencer for one column of row-stationary PEs: loads, starts, drains psums.
// Optional cycle counter enabled by defining PE_COLUMN_CTRL_PERF_EN.
module pe_column_ctrl #(
  parameter int numPE         = 3,
  parameter int dataSize      = 8,
  parameter int macResSize    = 20,
  parameter int rfNumRegister = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [7:0]            cfg_acount,
  input  logic [7:0]            cfg_wcount,
  input  logic [dataSize-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dataSize-1:0]   pe_data_o,
  output logic [numPE-1:0]      pe_loadw_o,
  output logic [numPE-1:0]      pe_loada_o,
  output logic                  pe_start_o,
  output logic                  pe_sums_o,
  input  logic [numPE-1:0]      pe_done_i,
  input  logic [macResSize-1:0] top_psum_i,
  output logic [macResSize-1:0] out_psum,
  output logic                  out_valid,
  output logic                  job_done,
  output logic                  err_cfg,
  output logic                  err_underrun,
  output logic [31:0]           perf_cycles
);

  localparam int PW = (numPE > 1) ? $clog2(numPE) : 1;
  localparam logic [numPE-1:0] ONE  = numPE'(1);
  localparam logic [PW-1:0]    LAST = PW'(numPE - 1);
  localparam logic [8:0]       AMAX = 9'(rfNumRegister);

  typedef enum logic [3:0] {
    IDLE, LOAD_W, GAP_W, LOAD_A, GAP_A,
    START, WAIT, SUMS, DRAIN
  } state_t;

  state_t           state;
  logic [7:0]       acnt;
  logic [7:0]       wcnt;
  logic [7:0]       k;
  logic [7:0]       scnt;
  logic             gap;
  logic [PW-1:0]    p;
  logic [numPE-1:0] mask;
  logic [numPE-1:0] done_q;
  logic [numPE-1:0] tok;

  logic       cfg_bad;
  logic       accept;
  logic [7:0] len;
  logic [7:0] nsum;

  assign job_ready = (state == IDLE) && !job_done;
  assign in_ready  = (state == LOAD_W) || (state == LOAD_A);
  assign accept    = job_valid && job_ready;
  assign len       = (state == LOAD_W) ? wcnt : acnt;
  assign nsum      = acnt - wcnt + 8'd1;
  assign cfg_bad   = (cfg_wcount == 8'd0)
                  || (cfg_acount < cfg_wcount)
                  || ({1'b0, cfg_acount} > AMAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      acnt         <= '0;
      wcnt         <= '0;
      k            <= '0;
      scnt         <= '0;
      gap          <= 1'b0;
      p            <= '0;
      mask         <= '0;
      done_q       <= '0;
      tok          <= '0;
      pe_data_o    <= '0;
      pe_loadw_o   <= '0;
      pe_loada_o   <= '0;
      pe_start_o   <= 1'b0;
      pe_sums_o    <= 1'b0;
      out_psum     <= '0;
      out_valid    <= 1'b0;
      job_done     <= 1'b0;
      err_cfg      <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      pe_loadw_o <= '0;
      pe_loada_o <= '0;
      pe_start_o <= 1'b0;
      job_done   <= 1'b0;
      err_cfg    <= 1'b0;
      out_valid  <= 1'b0;
      done_q     <= pe_done_i;
      // token line mirrors the psum hop delay up the column
      tok <= (tok << 1) | (pe_sums_o ? ONE : '0);
      if (tok[numPE-1]) begin
        out_psum  <= top_psum_i;
        out_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            acnt <= cfg_acount;
            wcnt <= cfg_wcount;
            p    <= '0;
            k    <= '0;
            if (cfg_bad) err_cfg <= 1'b1;
            else         state   <= LOAD_W;
          end
        end
        LOAD_W, LOAD_A: begin
          // a missing word repeats the last one; PEs cannot stall
          if (in_valid) pe_data_o    <= in_data;
          else          err_underrun <= 1'b1;
          if (k == 8'd0) begin
            if (state == LOAD_W) pe_loadw_o <= ONE << p;
            else                 pe_loada_o <= ONE << p;
          end
          if (k == len - 8'd1) begin
            k     <= '0;
            gap   <= 1'b0;
            state <= (state == LOAD_W) ? GAP_W : GAP_A;
          end else begin
            k <= k + 8'd1;
          end
        end
        GAP_W, GAP_A: begin
          if (!gap) begin
            gap <= 1'b1;
          end else if (p == LAST) begin
            p     <= '0;
            state <= (state == GAP_W) ? LOAD_A : START;
          end else begin
            p     <= p + PW'(1);
            state <= (state == GAP_W) ? LOAD_W : LOAD_A;
          end
        end
        START: begin
          pe_start_o <= 1'b1;
          mask       <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          // done is level-sticky, so only fresh edges count
          mask <= mask | (pe_done_i & ~done_q);
          if (&mask) begin
            pe_sums_o <= 1'b1;
            scnt      <= 8'd1;
            state     <= SUMS;
          end
        end
        SUMS: begin
          if (scnt == nsum) begin
            pe_sums_o <= 1'b0;
            state     <= DRAIN;
          end else begin
            scnt <= scnt + 8'd1;
          end
        end
        DRAIN: begin
          if (tok == '0) begin
            job_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PE_COLUMN_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == IDLE) begin
        if (accept) perf_cnt <= '0;
      end else if (perf_cnt != '1) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if (job_done) perf_cycles <= perf_cnt;
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_column_ctrl.sv
// Directed bench for pe_column_ctrl with a behavioural PE column model.
// Expected load events and psums are queued at job start, popped on output.
module tb_pe_column_ctrl;

  localparam int NPE = 3;
  localparam int DS  = 8;
  localparam int MR  = 20;
  localparam int RF  = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic          job_valid;
  logic          job_ready;
  logic [7:0]    cfg_acount;
  logic [7:0]    cfg_wcount;
  logic [DS-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DS-1:0] pe_data_o;
  logic [NPE-1:0] pe_loadw_o;
  logic [NPE-1:0] pe_loada_o;
  logic          pe_start_o;
  logic          pe_sums_o;
  logic [NPE-1:0] pe_done_i;
  logic [MR-1:0] top_psum_i;
  logic [MR-1:0] out_psum;
  logic          out_valid;
  logic          job_done;
  logic          err_cfg;
  logic          err_underrun;
  logic [31:0]   perf_cycles;

  pe_column_ctrl #(
    .numPE(NPE), .dataSize(DS),
    .macResSize(MR), .rfNumRegister(RF)
  ) dut (
    .clk(clk), .nrst(nrst),
    .job_valid(job_valid), .job_ready(job_ready),
    .cfg_acount(cfg_acount), .cfg_wcount(cfg_wcount),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pe_data_o(pe_data_o),
    .pe_loadw_o(pe_loadw_o), .pe_loada_o(pe_loada_o),
    .pe_start_o(pe_start_o), .pe_sums_o(pe_sums_o),
    .pe_done_i(pe_done_i), .top_psum_i(top_psum_i),
    .out_psum(out_psum), .out_valid(out_valid),
    .job_done(job_done), .err_cfg(err_cfg),
    .err_underrun(err_underrun),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  int stream[$];
  int slots[$];
  int exp_ld[$];
  int exp_ps[$];
  int sidx, slot_in, slot_pres, drop;
  bit prev_rdy;
  int cw, ca, acc;
  int pw[NPE][RF];
  int pa[NPE][RF];
  int wc[NPE];
  int ac[NPE];
  int tmr[NPE];
  int dly[NPE];
  logic [MR-1:0] line[NPE+1];
  int sum_j, nout, done_seen, err_seen, pe_act;
  int done_cyc, rise1_cyc, sums1_cyc;
  bit seen_la;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh(input logic [NPE-1:0] v);
    for (int i = 0; i < NPE; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic int colsum(input int j);
    int s = 0;
    for (int q = 0; q < NPE; q++)
      for (int i = 0; i < cw; i++)
        if (j + i < RF) s += pw[q][i] * pa[q][j+i];
    return s;
  endfunction

  // one clock: observe cycle outputs at negedge, model PEs, drive stream
  task automatic tick();
    int cur;
    @(negedge clk);
    cyc++;
    for (int q = 0; q < NPE; q++) begin
      if (pe_loadw_o[q]) begin
        pw[q][0] = int'(pe_data_o); wc[q] = 1;
      end else if (wc[q] > 0 && wc[q] < cw) begin
        pw[q][wc[q]] = int'(pe_data_o); wc[q]++;
      end
      if (pe_loada_o[q]) begin
        pa[q][0] = int'(pe_data_o); ac[q] = 1;
      end else if (ac[q] > 0 && ac[q] < ca) begin
        pa[q][ac[q]] = int'(pe_data_o); ac[q]++;
      end
    end
    cur = slot_pres;
    if (prev_rdy) slot_pres++;
    if (pe_loadw_o != '0 || pe_loada_o != '0) begin
      int code;
      if (pe_loada_o != '0) seen_la = 1'b1;
      code = (pe_loada_o != '0 ? 1000 : 0)
           + oh(pe_loadw_o | pe_loada_o) * 100 + cur;
      if (exp_ld.size() > 0) chk("ld_evt", code, exp_ld.pop_front());
      else chk("ld_extra", code, 32'hFFFF_FFFF);
    end
    if (pe_loadw_o != '0 || pe_loada_o != '0 || pe_start_o || pe_sums_o)
      pe_act++;
    for (int q = 0; q < NPE; q++) begin
      if (pe_start_o) begin
        pe_done_i[q] = 1'b0; tmr[q] = dly[q];
      end else if (tmr[q] > 0) begin
        tmr[q]--;
        if (tmr[q] == 0) begin
          pe_done_i[q] = 1'b1;
          if (q == 1) rise1_cyc = cyc;
        end
      end
    end
    if (pe_sums_o && sums1_cyc < 0) sums1_cyc = cyc;
    for (int h = NPE; h > 0; h--) line[h] = line[h-1];
    line[0] = pe_sums_o ? MR'(colsum(sum_j)) : '0;
    if (pe_sums_o) sum_j++;
    top_psum_i = line[NPE];
    if (out_valid) begin
      nout++;
      if (exp_ps.size() > 0) chk("psum", out_psum, exp_ps.pop_front());
    end
    if (job_done) begin
      done_seen++; done_cyc = cyc;
      chk("rdy_at_done", job_ready, 0);
    end
    if (err_cfg) err_seen++;
    in_valid = !(in_ready && slot_in == drop);
    in_data  = (sidx < stream.size()) ? DS'(stream[sidx]) : 8'hEE;
    if (in_ready) begin
      if (in_valid) sidx++;
      slot_in++;
    end
    prev_rdy = in_ready;
  endtask

  task automatic start_job(input int A, input int W, input int drp,
                           input int d0, input int d1, input int d2);
    int tot, n, b;
    cw = W; ca = A; drop = drp;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    sidx = 0; slot_in = 0; slot_pres = 0; sum_j = 0;
    nout = 0; done_seen = 0; sums1_cyc = -1; rise1_cyc = -1;
    seen_la = 1'b0;
    for (int q = 0; q < NPE; q++) begin wc[q] = 0; ac[q] = 0; end
    tot = NPE * (W + A);
    n   = A - W + 1;
    stream.delete(); slots.delete();
    for (int i = 0; i < tot; i++) stream.push_back($urandom_range(0, 15));
    for (int i = 0; i < tot; i++) begin
      if (drp < 0 || i < drp) slots.push_back(stream[i]);
      else if (i == drp)      slots.push_back(slots[i-1]);
      else                    slots.push_back(stream[i-1]);
    end
    for (int q = 0; q < NPE; q++) exp_ld.push_back(q * 100 + q * W);
    for (int q = 0; q < NPE; q++)
      exp_ld.push_back(1000 + q * 100 + NPE * W + q * A);
    for (int j = 0; j < n; j++) begin
      int s = 0;
      for (int q = 0; q < NPE; q++)
        for (int i = 0; i < W; i++)
          s += slots[q*W + i] * slots[NPE*W + q*A + j + i];
      exp_ps.push_back(s);
    end
    b = 0;
    while (!job_ready && b < 50) begin tick(); b++; end
    chk("job_ready", job_ready, 1);
    cfg_acount = 8'(A); cfg_wcount = 8'(W);
    job_valid = 1'b1; acc = cyc;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input int n);
    int b = 0;
    while (done_seen == 0 && b < 3000) begin tick(); b++; end
    chk("job_done", done_seen, 1);
    chk("n_out", nout, n);
    chk("ps_q_empty", exp_ps.size(), 0);
    chk("ld_q_empty", exp_ld.size(), 0);
    chk("words", sidx, NPE * (cw + ca) - (drop >= 0 ? 1 : 0));
    tick();
`ifdef PE_COLUMN_CTRL_PERF_EN
    chk("perf", perf_cycles, done_cyc - acc - 1);
`else
    chk("perf_off", perf_cycles, 0);
`endif
  endtask

  task automatic cfg_err(input int A, input int W);
    int b = 0;
    while (!job_ready && b < 50) begin tick(); b++; end
    pe_act = 0; err_seen = 0; done_seen = 0;
    cfg_acount = 8'(A); cfg_wcount = 8'(W);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("err_cfg", err_cfg, 1);
    chk("rdy_cfg", job_ready, 1);
    repeat (6) tick();
    chk("err_pulse", err_seen, 1);
    chk("pe_quiet", pe_act, 0);
    chk("in_rdy_cfg", in_ready, 0);
    chk("no_done_cfg", done_seen, 0);
  endtask

  initial begin
    nrst = 1'b0; job_valid = 1'b0; cfg_acount = '0; cfg_wcount = '0;
    in_data = '0; in_valid = 1'b0; pe_done_i = '0; top_psum_i = '0;
    drop = -1; prev_rdy = 1'b0; cw = 1; ca = 1;
    for (int h = 0; h <= NPE; h++) line[h] = '0;
    for (int q = 0; q < NPE; q++) begin
      tmr[q] = 0; dly[q] = 3; wc[q] = 0; ac[q] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", job_ready, 1);
    chk("rst_outs", {pe_data_o, pe_loadw_o, pe_loada_o, pe_start_o,
                     pe_sums_o, out_valid, job_done, err_cfg,
                     err_underrun, in_ready}, 0);
    chk("rst_psum", out_psum, 0);
    chk("rst_perf", perf_cycles, 0);
    nrst = 1'b1;

    start_job(5, 3, -1, 3, 3, 3);
    finish_job(3);
    chk("undr0", err_underrun, 0);

    cfg_err(2, 3);
    cfg_err(17, 3);
    cfg_err(4, 0);

    start_job(5, 3, -1, 3, 13, 3);
    finish_job(3);
    chk("late_d1_seen", rise1_cyc > 0, 1);
    chk("sums_after_d1", sums1_cyc > rise1_cyc, 1);

    start_job(4, 2, -1, 2, 4, 1);
    finish_job(3);
    start_job(6, 3, -1, 5, 1, 2);
    finish_job(4);

    start_job(5, 3, 5, 3, 3, 3);
    finish_job(3);
    chk("undr1", err_underrun, 1);

    start_job(5, 3, -1, 3, 3, 3);
    begin
      int b = 0;
      while (!seen_la && b < 200) begin tick(); b++; end
    end
    chk("reached_la", seen_la, 1);
    tick();
    nrst = 1'b0;
    #1;
    chk("mid_rst_ready", job_ready, 1);
    chk("mid_rst_outs", {pe_data_o, pe_loadw_o, pe_loada_o, pe_start_o,
                         pe_sums_o, out_valid, job_done, err_cfg,
                         err_underrun, in_ready}, 0);
    chk("mid_rst_psum", out_psum, 0);
    exp_ld.delete(); exp_ps.delete();
    @(negedge clk);
    nrst = 1'b1;
    done_seen = 0; drop = -1;
    repeat (60) tick();
    chk("no_done_rst", done_seen, 0);
    chk("rdy_after_rst", job_ready, 1);

    start_job(4, 2, -1, 2, 2, 2);
    finish_job(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
